// File: rtl/alu_pkg.sv
// Shared definitions for the tiny_4bit_alu command sequencer.
// Contents: ALU opcode constants, uo_out flag bit positions, the sequencer FSM
// state type and the result-compare helper shared by the sequencer and checker.
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'b0000;
    localparam logic [3:0] OP_PASS_B    = 4'b0111;
    localparam logic [3:0] OP_REG_WRITE = 4'b1000;
    localparam logic [3:0] OP_REG_READ  = 4'b1001;
    localparam logic [3:0] OP_ADD_REG   = 4'b1010;
    localparam logic [3:0] OP_SUB_REG   = 4'b1011;

    // Bit positions of the status flags inside uo_out.
    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_V = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // A register write has no meaningful result, so it never reports a mismatch.
    function automatic logic result_mismatch(input logic [3:0] op,
                                             input logic       chk,
                                             input logic [3:0] result,
                                             input logic [3:0] exp_val);
        return chk && (op != OP_REG_WRITE) && (result != exp_val);
    endfunction

endpackage

// File: rtl/alu_rsp_checker.sv
// Response checker: compares the sampled ALU result against the expected value
// and keeps a saturating mismatch counter.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   sample_en    pulse on the cycle the response is captured
//   err_clr      synchronous counter clear (wins over a same-cycle increment)
//   op, chk, exp_val  latched command fields
//   result       live ALU result (uo_out[3:0])
//   mismatch     combinational compare outcome for the current result
//   err_count    saturating mismatch count
module alu_rsp_checker
    import alu_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             err_clr,
    input  logic [3:0]       op,
    input  logic             chk,
    input  logic [3:0]       exp_val,
    input  logic [3:0]       result,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    logic             mismatch_s;
    logic [ERR_W-1:0] err_count_r;

    // Compare the live result against the expected value.
    always_comb begin
        mismatch_s = result_mismatch(op, chk, result, exp_val);
    end

    // Saturating mismatch counter; a clear in the same cycle beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {ERR_W{1'b0}};
        end else if (err_clr) begin
            err_count_r <= {ERR_W{1'b0}};
        end else if (sample_en && mismatch_s && (err_count_r != {ERR_W{1'b1}})) begin
            err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign mismatch  = mismatch_s;
    assign err_count = err_count_r;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the tiny_4bit_alu pin interface. Accepts one command
// at a time, drives ui_in={B,A} / uio={0,op}, waits WAIT_CYCLES edges for the
// ALU to settle, samples uo_out and returns {result, flags, mismatch}.
// Ports:
//   cmd_valid/cmd_ready + cmd_op/a/b/chk/exp   command stream in
//   alu_ui_in, alu_uio (out), alu_uo_out (in)   ALU pins
//   rsp_valid/rsp_ready + rsp_result/flags/mismatch   response stream out
//   err_clr, err_count                          mismatch counter control/status
//   busy                                        high whenever not idle
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_chk,
    input  logic [3:0]       cmd_exp,
    output logic [7:0]       alu_ui_in,
    output logic [7:0]       alu_uio,
    input  logic [7:0]       alu_uo_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_mismatch,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    seq_state_t state_r;
    logic [3:0] op_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic       chk_r;
    logic [3:0] exp_r;
    logic [3:0] cnt_r;
    logic [7:0] ui_in_r;
    logic [7:0] uio_r;
    logic       cmd_ready_r;
    logic       busy_r;
    logic       rsp_valid_r;
    logic [3:0] rsp_result_r;
    logic [3:0] rsp_flags_r;
    logic       rsp_mismatch_r;
    logic       sample_s;
    logic       mismatch_s;

    // Sample strobe: last settle cycle of WAIT (<= guards a corrupted count of 0).
    always_comb begin
        if ((state_r == ST_WAIT) && (cnt_r <= 4'd1)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
    end

    alu_rsp_checker #(
        .ERR_W (ERR_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_s),
        .err_clr   (err_clr),
        .op        (op_r),
        .chk       (chk_r),
        .exp_val   (exp_r),
        .result    (alu_uo_out[3:0]),
        .mismatch  (mismatch_s),
        .err_count (err_count)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            op_r           <= 4'd0;
            a_r            <= 4'd0;
            b_r            <= 4'd0;
            chk_r          <= 1'b0;
            exp_r          <= 4'd0;
            cnt_r          <= 4'd0;
            ui_in_r        <= 8'd0;
            uio_r          <= 8'd0;
            cmd_ready_r    <= 1'b0;
            busy_r         <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= 4'd0;
            rsp_flags_r    <= 4'd0;
            rsp_mismatch_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ui_in_r <= 8'd0;
                    uio_r   <= 8'd0;
                    if (cmd_valid && cmd_ready_r) begin
                        op_r        <= cmd_op;
                        a_r         <= cmd_a;
                        b_r         <= cmd_b;
                        chk_r       <= cmd_chk;
                        exp_r       <= cmd_exp;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_DRIVE;
                    end else begin
                        // Also raises ready on the first cycle after reset.
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    ui_in_r <= {b_r, a_r};
                    uio_r   <= {4'b0000, op_r};
                    cnt_r   <= WAIT_LOAD;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sample_s) begin
                        rsp_result_r   <= alu_uo_out[3:0];
                        rsp_flags_r    <= alu_uo_out[FLAG_Z:FLAG_C];
                        rsp_mismatch_r <= mismatch_s;
                        rsp_valid_r    <= 1'b1;
                        state_r        <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Pins stay on the command until the response is taken.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ui_in_r     <= 8'd0;
                        uio_r       <= 8'd0;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    ui_in_r     <= 8'd0;
                    uio_r       <= 8'd0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign busy         = busy_r;
    assign alu_ui_in    = ui_in_r;
    assign alu_uio      = uio_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_flags    = rsp_flags_r;
    assign rsp_mismatch = rsp_mismatch_r;

endmodule
